mul_div_unit_e: RTL and testbench
=================================

# mul_div_unit_e

Iterative RV32M multiply/divide unit in the execute stage. It consumes the forwarded ALU operands (post-forwarding operand 1 and operand 2) for M-extension instructions and produces a 32-bit result after a multi-cycle computation. While the computation runs, it raises a stall request to the hazard unit, and the result is handed to the EX/MEM register.

## Interface
- No parameters; width fixed at 32.
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  EX holds a valid M-extension instruction; sampled only in IDLE.
- iFunct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iOp1  input  32  forwarded operand 1 (rs1 value).
- iOp2  input  32  forwarded operand 2 (rs2 value).
- iFlush  input  1  cancel any operation in flight (branch/jump flush of EX).
- oBusy  output  1  stall request to hazard unit.
- oDone  output  1  result valid this cycle, one-cycle pulse.
- oResult  output  32  result; holds last value until the next completion.
- One clock domain. Reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - If iStart=1 and iFlush=0, latch the operands, funct3 and sign info.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1) with the counter at 31.
- Signed handling:
  - Operands are converted to magnitudes per op: MULH, DIV and REM treat both as signed; MULHSU treats only op1 as signed; others are unsigned.
  - The result is negated at the end where required:
    - product: if the operand signs differ.
    - quotient: if the dividend and divisor signs differ.
    - remainder: takes the sign of the dividend.
- MUL:
  - Shift-add, one multiplier bit per cycle, 64-bit accumulator.
  - After 32 iterations, go to DONE.
  - MUL returns product[31:0]; the MULH* ops return product[63:32].
- DIV:
  - Restoring division, one quotient bit per cycle, 33-bit partial remainder.
  - After 32 iterations, go to DONE.
- Special cases, detected in IDLE. Go directly to DONE with no iteration:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = iOp1.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- DONE:
  - oDone=1 and oResult is registered and valid.
  - iStart is ignored.
  - Unconditionally go to IDLE on the next edge.
- iFlush in any state: go to IDLE next edge; no oDone is produced; oResult is unchanged. iFlush has priority over iStart.
- iStart while in MUL or DIV is ignored; operands stay latched.

## Timing
- Reset values: state IDLE, counter 0, oResult 0x00000000, oDone 0. oBusy is 0 unless iStart is asserted in IDLE.
- oBusy is combinational: 1 when (IDLE and iStart and not iFlush) or the state is MUL or DIV; 0 in DONE.
  - The stall therefore covers the start cycle itself.
  - The stall releases in the DONE cycle, so the instruction leaves EX at the end of DONE.
- Latency, start accepted at edge 0:
  - Iterative: oDone is high in cycle 33 (32 iteration cycles, then DONE).
  - Special-case division: oDone is high in cycle 1.
- Back-to-back: a new iStart is accepted in the IDLE cycle immediately after DONE. Minimum spacing is 2 cycles (fast path) or 34 cycles (iterative).
- Reset asserted mid-operation: asynchronous return to IDLE. oDone drops immediately, and no partial result is ever presented.

## Configuration
- MULDIV_FAST_MUL_EN
  - Defined: MUL-class ops use a single-cycle 33x33 signed multiply in IDLE and go directly to DONE, with oDone in cycle 1. The MUL state and shift-add datapath are compiled out.
  - Undefined: the iterative 32-cycle shift-add is used. Division is iterative in both builds.

## Structure
- Package muldiv_pkg holds:
  - funct3 op enum (MULDIV_MUL .. MULDIV_REMU).
  - FSM state enum.
  - Constant XLEN=32 and the iteration count.
  - The divide-by-zero and overflow result constants.
- One sub-module, muldiv_sign_fix: combinational operand-magnitude and result-negation logic shared by the multiply and divide paths.

## Test plan
- MUL, 7 x 0xFFFFFFFD (-3) -> oResult 0xFFFFFFEB.
  - Iterative build: oDone in cycle 33, with oBusy high in cycles 0–32.
  - Fast build: oDone in cycle 1.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Special cases, each with oDone in cycle 1:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Flush: iFlush at cycle 10 of a DIV -> state IDLE at cycle 11, no oDone, oResult unchanged. A new DIVU 9/3 starting at cycle 11 -> 3 in cycle 44.
- Reset mid-operation: iRst at cycle 5 of a MUL -> oBusy 0 and oDone 0 immediately, oResult 0x00000000. A later MUL 6 x 7 -> 42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the RV32M multiply/divide unit:
//   - op_e     : funct3 encoding of the M-extension operations
//   - state_e  : FSM states of the iterative engine
//   - XLEN, iteration count, divide-by-zero / overflow result constants
//   - helpers telling which operands are treated as signed for a given op
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST = 5'(ITER_COUNT - 1);

  localparam logic [XLEN-1:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM      = 32'h0000_0000;
  localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // rs1 is signed for MULH, MULHSU, DIV and REM
  function automatic logic op1_is_signed(input logic [2:0] f3);
    case (f3)
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM: op1_is_signed = 1'b1;
      default:                                            op1_is_signed = 1'b0;
    endcase
  endfunction

  // rs2 is signed for MULH, DIV and REM
  function automatic logic op2_is_signed(input logic [2:0] f3);
    case (f3)
      MULDIV_MULH, MULDIV_DIV, MULDIV_REM: op2_is_signed = 1'b1;
      default:                             op2_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_unit_e_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_e_if
// Request/response bundle between the EX stage and the multiply/divide unit.
//   iStart, iFunct3, iOp1, iOp2, iFlush : requester -> unit
//   oBusy, oDone, oResult               : unit -> requester
// Modports: master (EX stage / bench side), slave (the unit).
// -----------------------------------------------------------------------------
interface mul_div_unit_e_if;
  logic        iStart;
  logic [2:0]  iFunct3;
  logic [31:0] iOp1;
  logic [31:0] iOp2;
  logic        iFlush;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  modport master (
    output iStart, iFunct3, iOp1, iOp2, iFlush,
    input  oBusy, oDone, oResult
  );

  modport slave (
    input  iStart, iFunct3, iOp1, iOp2, iFlush,
    output oBusy, oDone, oResult
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational sign handling shared by the multiply and divide paths.
// Front side: funct3/op1/op2 -> operand magnitudes (mag1, mag2) plus the flags
//   neg_a (product/quotient must be negated) and neg_r (dividend negative).
// Back side: latched op and flags plus the unsigned magnitude results
//   (prod, quot, rem) -> final 32-bit architectural result.
// -----------------------------------------------------------------------------
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  output logic [XLEN-1:0]   mag1,
  output logic [XLEN-1:0]   mag2,
  output logic              neg_a,
  output logic              neg_r,
  input  logic [2:0]        res_op,
  input  logic              res_neg_a,
  input  logic              res_neg_r,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quot,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);

  logic              s1_s;
  logic              s2_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct magnitude
  always_comb begin
    s1_s  = op1_is_signed(funct3) & op1[XLEN-1];
    s2_s  = op2_is_signed(funct3) & op2[XLEN-1];
    mag1  = s1_s ? (32'd0 - op1) : op1;
    mag2  = s2_s ? (32'd0 - op2) : op2;
    neg_a = s1_s ^ s2_s;
    neg_r = s1_s;
  end

  // Re-apply signs to the magnitude results and select the part the op returns
  always_comb begin
    prod_fix_s = res_neg_a ? (64'd0 - prod) : prod;
    quot_fix_s = res_neg_a ? (32'd0 - quot) : quot;
    rem_fix_s  = res_neg_r ? (32'd0 - rem) : rem;
    case (res_op)
      MULDIV_MUL:                               result = prod_fix_s[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                  result = quot_fix_s;
      default:                                  result = rem_fix_s;
    endcase
  end

endmodule

// File: rtl/mul_div_unit_e.sv
// -----------------------------------------------------------------------------
// mul_div_unit_e
// Iterative RV32M multiply/divide unit in the execute stage.
// Ports:
//   iClk  : clock, rising edge
//   iRst  : asynchronous active-high reset
//   bus   : mul_div_unit_e_if.slave (iStart, iFunct3, iOp1, iOp2, iFlush ->
//           oBusy (combinational stall), oDone (1-cycle pulse), oResult (held))
// Build option: MULDIV_FAST_MUL_EN - when defined, MUL-class ops complete in a
//   single-cycle 33x33 signed multiply; when undefined, a 32-cycle shift-add
//   is used. Division is iterative (restoring) in both builds.
// -----------------------------------------------------------------------------
module mul_div_unit_e
  import muldiv_pkg::*;
(
  input logic             iClk,
  input logic             iRst,
  mul_div_unit_e_if.slave bus
);

  state_e          state_r;
  logic [4:0]      cnt_r;
  logic [2:0]      op_r;
  logic            neg_a_r;
  logic            neg_r_r;
  logic [XLEN-1:0] a_r;       // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] b_r;       // divisor magnitude
  logic [XLEN-1:0] rem_r;     // partial remainder
  logic [XLEN-1:0] result_r;
  logic            done_r;

  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              neg_a_s;
  logic              neg_r_s;
  logic [XLEN:0]     shl_s;
  logic              ge_s;
  logic [XLEN-1:0]   a_nxt_s;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fixed_s;
  logic              div0_s;
  logic              ovf_s;

`ifndef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] acc_r;   // high half: running sum, low half: multiplier bits
  logic [XLEN:0]     add_s;
  logic [2*XLEN-1:0] acc_nxt_s;

  // One shift-add step: add multiplicand when the current multiplier bit is set, shift right
  always_comb begin
    add_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, a_r} : 33'd0);
    acc_nxt_s = {add_s, acc_r[XLEN-1:1]};
    prod_s    = acc_nxt_s;
  end
`else
  logic [2*XLEN-1:0] fa_s;
  logic [2*XLEN-1:0] fb_s;
  logic [2*XLEN-1:0] fp_s;
  logic [XLEN-1:0]   fast_res_s;

  // Single-cycle product of sign-extended operands; low 64 bits are exact
  always_comb begin
    fa_s   = {{32{op1_is_signed(bus.iFunct3) & bus.iOp1[XLEN-1]}}, bus.iOp1};
    fb_s   = {{32{op2_is_signed(bus.iFunct3) & bus.iOp2[XLEN-1]}}, bus.iOp2};
    fp_s   = fa_s * fb_s;
    prod_s = 64'd0;
    if (bus.iFunct3 == MULDIV_MUL) begin
      fast_res_s = fp_s[XLEN-1:0];
    end else begin
      fast_res_s = fp_s[2*XLEN-1:XLEN];
    end
  end
`endif

  // One restoring-division step on a 33-bit shifted partial remainder
  always_comb begin
    shl_s = {rem_r, a_r[XLEN-1]};
    ge_s  = (shl_s >= {1'b0, b_r});
    if (ge_s) begin
      rem_nxt_s = shl_s[XLEN-1:0] - b_r;
      a_nxt_s   = {a_r[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_s = shl_s[XLEN-1:0];
      a_nxt_s   = {a_r[XLEN-2:0], 1'b0};
    end
  end

  // Division special cases resolved without iterating
  always_comb begin
    div0_s = (bus.iOp2 == 32'd0);
    ovf_s  = !bus.iFunct3[0] && (bus.iOp1 == OVF_DIVIDEND) && (bus.iOp2 == OVF_DIVISOR);
  end

  muldiv_sign_fix u_sign_fix (
    .funct3    (bus.iFunct3),
    .op1       (bus.iOp1),
    .op2       (bus.iOp2),
    .mag1      (mag1_s),
    .mag2      (mag2_s),
    .neg_a     (neg_a_s),
    .neg_r     (neg_r_s),
    .res_op    (op_r),
    .res_neg_a (neg_a_r),
    .res_neg_r (neg_r_r),
    .prod      (prod_s),
    .quot      (a_nxt_s),
    .rem       (rem_nxt_s),
    .result    (fixed_s)
  );

  // Control FSM and datapath registers; the result is captured on entry to DONE
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      op_r     <= 3'd0;
      neg_a_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      rem_r    <= 32'd0;
      result_r <= 32'd0;
      done_r   <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      acc_r    <= 64'd0;
`endif
    end else if (bus.iFlush) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.iStart) begin
            op_r    <= bus.iFunct3;
            neg_a_r <= neg_a_s;
            neg_r_r <= neg_r_s;
            a_r     <= mag1_s;
            b_r     <= mag2_s;
            cnt_r   <= ITER_LAST;
            if (bus.iFunct3[2]) begin
              if (div0_s) begin
                result_r <= bus.iFunct3[1] ? bus.iOp1 : DIV0_QUOT;
                done_r   <= 1'b1;
                state_r  <= ST_DONE;
              end else if (ovf_s) begin
                result_r <= bus.iFunct3[1] ? OVF_REM : OVF_QUOT;
                done_r   <= 1'b1;
                state_r  <= ST_DONE;
              end else begin
                rem_r   <= 32'd0;
                state_r <= ST_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_r <= fast_res_s;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
`else
              acc_r   <= {32'd0, mag2_s};
              state_r <= ST_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        ST_MUL: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd0) begin
            result_r <= fixed_s;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
`endif
        ST_DIV: begin
          a_r   <= a_nxt_s;
          rem_r <= rem_nxt_s;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd0) begin
            result_r <= fixed_s;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle and all iteration cycles, released in DONE
  assign bus.oBusy   = ((state_r == ST_IDLE) && bus.iStart && !bus.iFlush) ||
                       (state_r == ST_MUL) || (state_r == ST_DIV);
  assign bus.oDone   = done_r;
  assign bus.oResult = result_r;

endmodule

// File: tb/tb_mul_div_unit_e.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit_e
// Self-checking bench for mul_div_unit_e: directed RV32M vectors, randomized
// operations against an arithmetic reference model, back-to-back starts,
// flush and asynchronous reset during an operation.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_mul_div_unit_e;

  logic iClk;
  logic iRst;
  int   total;
  int   bad;

  mul_div_unit_e_if bus ();

  mul_div_unit_e dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // RV32M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: begin p = 64'(ua * ub); r = longint'({32'd0, p[63:32]}); end
      3'd4: r = (b == 32'd0) ? -64'sd1 : sa / sb;
      3'd5: r = (b == 32'd0) ? -64'sd1 : ua / ub;
      3'd6: r = (b == 32'd0) ? sa : sa % sb;
      default: r = (b == 32'd0) ? ua : ua % ub;
    endcase
    p = r;
    return p[31:0];
  endfunction

  // Cycle (after the accepting edge) in which oDone is expected
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 32'd0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Start an op in the current (IDLE) cycle; check busy profile, latency, result, hold
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int lat, cyc;
    bit busy_ok;
    lat = exp_lat(f3, a, b);
    busy_ok = 1'b1;
    bus.iStart = 1'b1; bus.iFunct3 = f3; bus.iOp1 = a; bus.iOp2 = b;
    #1;
    if (bus.oBusy !== 1'b1) busy_ok = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge iClk); #1;
      cyc++;
      bus.iStart  = (cyc < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.iFunct3 = 3'($urandom);
      bus.iOp1    = $urandom;
      bus.iOp2    = $urandom;
      #1;
      if (bus.oDone === 1'b1) break;
      if (bus.oBusy !== 1'b1) busy_ok = 1'b0;
    end
    if (bus.oBusy !== 1'b0) busy_ok = 1'b0;
    bus.iStart = 1'b0;
    total++;
    if (cyc !== lat) begin
      bad++; $display("FAIL %s latency: got cycle %0d want cycle %0d", tag, cyc, lat);
    end
    total++;
    if (bus.oResult !== exp) begin
      bad++; $display("FAIL %s result: got %h want %h", tag, bus.oResult, exp);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL %s busy: got irregular oBusy want 1 until DONE then 0", tag);
    end
    @(posedge iClk); #2;
    total++;
    if (bus.oDone !== 1'b0 || bus.oResult !== exp) begin
      bad++; $display("FAIL %s hold: got done=%b res=%h want done=0 res=%h", tag, bus.oDone, bus.oResult, exp);
    end
  endtask

  task automatic test_reset();
    bus.iStart = 1'b0; bus.iFunct3 = 3'd0; bus.iOp1 = 32'd0; bus.iOp2 = 32'd0; bus.iFlush = 1'b0;
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    total++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oResult !== 32'd0) begin
      bad++; $display("FAIL reset: got busy=%b done=%b res=%h want 0 0 00000000", bus.oBusy, bus.oDone, bus.oResult);
    end
    iRst = 1'b0;
    @(posedge iClk); #1;
    total++;
    if (bus.oDone !== 1'b0 || bus.oResult !== 32'd0) begin
      bad++; $display("FAIL reset_release: got done=%b res=%h want 0 00000000", bus.oDone, bus.oResult);
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_m1x2");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu_100_7");
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu_100_7");
    do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
    do_op(3'd6, 32'd5,         32'd0,         32'd5,         "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
  endtask

  task automatic test_random();
    logic [31:0] edge_vals [5];
    logic [2:0]  f3;
    logic [31:0] a, b;
    edge_vals[0] = 32'd0; edge_vals[1] = 32'd1; edge_vals[2] = 32'h8000_0000;
    edge_vals[3] = 32'hFFFF_FFFF; edge_vals[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      do_op(f3, a, b, ref_op(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
    end
  endtask

  task automatic test_back_to_back();
    bus.iStart = 1'b1; bus.iFunct3 = 3'd5; bus.iOp1 = 32'd20; bus.iOp2 = 32'd0;
    @(posedge iClk); #1;
    // DONE cycle: a new request must neither stall nor be taken yet
    bus.iFunct3 = 3'd7; bus.iOp1 = 32'd17; bus.iOp2 = 32'd5;
    #1;
    total++;
    if (bus.oDone !== 1'b1 || bus.oResult !== 32'hFFFF_FFFF || bus.oBusy !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got done=%b res=%h busy=%b want 1 ffffffff 0", bus.oDone, bus.oResult, bus.oBusy);
    end
    @(posedge iClk); #1;
    do_op(3'd7, 32'd17, 32'd5, 32'd2, "b2b_second");
    do_op(3'd0, 32'd12345, 32'd678, 32'd8369910, "b2b_third");
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    bit quiet;
    prev = bus.oResult;
    // flush wins over start in IDLE
    bus.iStart = 1'b1; bus.iFlush = 1'b1; bus.iFunct3 = 3'd5; bus.iOp1 = 32'd3; bus.iOp2 = 32'd0;
    #1;
    total++;
    if (bus.oBusy !== 1'b0) begin
      bad++; $display("FAIL flush_prio_busy: got %b want 0", bus.oBusy);
    end
    @(posedge iClk); #1;
    bus.iStart = 1'b0; bus.iFlush = 1'b0;
    #1;
    total++;
    if (bus.oDone !== 1'b0 || bus.oResult !== prev) begin
      bad++; $display("FAIL flush_prio_done: got done=%b res=%h want 0 %h", bus.oDone, bus.oResult, prev);
    end
    // flush a DIV in cycle 10
    bus.iStart = 1'b1; bus.iFunct3 = 3'd4; bus.iOp1 = 32'd1000; bus.iOp2 = 32'd7;
    quiet = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge iClk); #1;
      bus.iStart = 1'b0;
      bus.iFlush = (c == 10);
      #1;
      if (bus.oDone !== 1'b0 || bus.oResult !== prev || bus.oBusy !== 1'b1) quiet = 1'b0;
    end
    @(posedge iClk); #1;
    bus.iFlush = 1'b0;
    #1;
    total++;
    if (!quiet || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oResult !== prev) begin
      bad++; $display("FAIL flush_div: got busy=%b done=%b res=%h quiet=%b want 0 0 %h 1",
                      bus.oBusy, bus.oDone, bus.oResult, quiet, prev);
    end
    do_op(3'd5, 32'd9, 32'd3, 32'd3, "after_flush");
  endtask

  task automatic test_reset_mid();
`ifdef MULDIV_FAST_MUL_EN
    bus.iStart = 1'b1; bus.iFunct3 = 3'd5; bus.iOp1 = 32'd100; bus.iOp2 = 32'd7;
`else
    bus.iStart = 1'b1; bus.iFunct3 = 3'd0; bus.iOp1 = 32'h0001_2345; bus.iOp2 = 32'd777;
`endif
    repeat (5) begin
      @(posedge iClk); #1;
      bus.iStart = 1'b0;
    end
    iRst = 1'b1;
    #1;
    total++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oResult !== 32'd0) begin
      bad++; $display("FAIL reset_mid: got busy=%b done=%b res=%h want 0 0 00000000", bus.oBusy, bus.oDone, bus.oResult);
    end
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(posedge iClk); #1;
    do_op(3'd0, 32'd6, 32'd7, 32'd42, "mul_after_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
